// File: rtl/btb_repl_ctrl.sv
// btb_repl_ctrl: BTB per-set LRU owner, victim selection, single-entry write buffer and optional flush walk (BTB_FLUSH_EN)
module btb_repl_ctrl #(
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_index,
  input  logic             lk_hit,
  input  logic             lk_way,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_present,
  input  logic             upd_way,
  input  logic             wr_stall,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_index,
  output logic             wr_way,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             inv_en,
  output logic [IDX_W-1:0] inv_index,
  output logic [SETS-1:0]  lru_state
);
  logic             buf_valid_q, buf_present_q, buf_way_q;
  logic [IDX_W-1:0] buf_index_q;
  logic [SETS-1:0]  lru_q, lru_d;
  logic             walk, flush_start, hs;
`ifdef BTB_FLUSH_EN
  typedef enum logic {IDLE, WALK} state_t;
  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  assign walk        = state_q == WALK;
  assign flush_start = !walk && flush_req;
  // Flush walk: invalidate one set per cycle, leave after the last set (counter wraps to 0)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (walk) begin
      cnt_q <= cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(SETS - 1)) state_q <= IDLE;
    end else if (flush_req) begin
      state_q <= WALK;
      cnt_q   <= '0;
    end
  assign flush_busy = walk;
  assign inv_en     = walk;
  assign inv_index  = cnt_q;
`else
  logic unused_flush_req;
  assign unused_flush_req = flush_req;
  assign walk        = 1'b0;
  assign flush_start = 1'b0;
  assign flush_busy  = 1'b0;
  assign inv_en      = 1'b0;
  assign inv_index   = '0;
`endif
  assign wr_en     = buf_valid_q && !wr_stall && !walk;
  assign wr_index  = buf_index_q;
  assign wr_way    = buf_present_q ? buf_way_q : lru_q[buf_index_q];
  assign upd_ready = !walk && (!buf_valid_q || wr_en);
  assign hs        = upd_valid && upd_ready;
  assign lru_state = lru_q;
  // Update buffer: refill on handshake, retire on write, drop when a flush starts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_valid_q   <= 1'b0;
      buf_index_q   <= '0;
      buf_present_q <= 1'b0;
      buf_way_q     <= 1'b0;
    end else begin
      buf_valid_q <= !flush_start && (hs || (buf_valid_q && !wr_en));
      if (hs) begin
        buf_index_q   <= upd_index;
        buf_present_q <= upd_present;
        buf_way_q     <= upd_way;
      end
    end
  // Next LRU: walk clears one set; otherwise lookup hit then write, so a same-set write wins
  always_comb begin
    lru_d = lru_q;
    if (walk) lru_d[inv_index] = 1'b0;
    else begin
      if (lk_valid && lk_hit) lru_d[lk_index] = ~lk_way;
      if (wr_en) lru_d[buf_index_q] = ~wr_way;
    end
  end
  // LRU state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lru_q <= '0;
    else lru_q <= lru_d;
endmodule

// File: tb/tb_btb_repl_ctrl.sv
// tb_btb_repl_ctrl: directed table, corner sequences and random stimulus against a queue-based model of btb_repl_ctrl
module tb_btb_repl_ctrl;
  localparam int SETS = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic lk_valid = 0, lk_hit = 0, lk_way = 0, upd_valid = 0, upd_present = 0, upd_way = 0, wr_stall = 0, flush_req = 0;
  logic [IDX_W-1:0] lk_index = 0, upd_index = 0;
  logic upd_ready, wr_en, wr_way, flush_busy, inv_en;
  logic [IDX_W-1:0] wr_index, inv_index;
  logic [SETS-1:0] lru_state;

  btb_repl_ctrl #(.SETS(SETS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_index(lk_index), .lk_hit(lk_hit), .lk_way(lk_way),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_present(upd_present), .upd_way(upd_way),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .flush_req(flush_req),
    .flush_busy(flush_busy), .inv_en(inv_en), .inv_index(inv_index), .lru_state(lru_state));

  always #5 clk = ~clk;

  typedef struct {
    logic lv; logic [2:0] li; logic lh, lw;
    logic uv; logic [2:0] ui; logic up, uw;
    logic st, fr, tab;
    logic e_en; logic [2:0] e_idx; logic e_way, e_rdy; logic [7:0] e_lru;
  } vec_t;
  typedef struct { int idx; bit pres; bit way; } ent_t;

  int n_chk = 0, n_fail = 0;
  bit lru_m [SETS];
  ent_t bq[$];
  int walk_left, walk_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lru_vec();
    logic [7:0] v;
    for (int i = 0; i < SETS; i++) v[i] = lru_m[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SETS; i++) lru_m[i] = 0;
    bq.delete();
    walk_left = 0;
    walk_idx = 0;
  endfunction

  function automatic vec_t mk(logic lv, logic [2:0] li, logic lh, logic lw, logic uv, logic [2:0] ui, logic up, logic uw,
                              logic st, logic e_en, logic [2:0] e_idx, logic e_way, logic e_rdy, logic [7:0] e_lru);
    vec_t v;
    v = '{lv, li, lh, lw, uv, ui, up, uw, st, 1'b0, 1'b1, e_en, e_idx, e_way, e_rdy, e_lru};
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.tab = 0;
    return v;
  endfunction

  // one clock cycle: drive, compare against model (and table), then advance the model at the edge
  task automatic step(input vec_t v);
    bit busy, en, way, rdy;
    lk_valid = v.lv; lk_index = v.li; lk_hit = v.lh; lk_way = v.lw;
    upd_valid = v.uv; upd_index = v.ui; upd_present = v.up; upd_way = v.uw;
    wr_stall = v.st; flush_req = v.fr;
    #1;
    busy = walk_left > 0;
    en = bq.size() > 0 && !v.st && !busy;
    way = en ? (bq[0].pres ? bq[0].way : lru_m[bq[0].idx]) : 1'b0;
    rdy = !busy && (bq.size() == 0 || en);
    chk("wr_en", wr_en, en);
    if (en) begin
      chk("wr_index", wr_index, bq[0].idx);
      chk("wr_way", wr_way, way);
    end
    chk("upd_ready", upd_ready, rdy);
    chk("flush_busy", flush_busy, busy);
    chk("inv_en", inv_en, busy);
    if (busy) chk("inv_index", inv_index, walk_idx);
    chk("lru_state", lru_state, lru_vec());
    if (v.tab) begin
      chk("tab_wr_en", wr_en, v.e_en);
      if (v.e_en) begin
        chk("tab_wr_index", wr_index, v.e_idx);
        chk("tab_wr_way", wr_way, v.e_way);
      end
      chk("tab_upd_ready", upd_ready, v.e_rdy);
      chk("tab_lru_state", lru_state, v.e_lru);
    end
    @(posedge clk);
    if (busy) begin
      lru_m[walk_idx] = 0;
      walk_idx = (walk_idx + 1) % SETS;
      walk_left--;
    end else begin
      if (v.lv && v.lh) lru_m[v.li] = !v.lw;
      if (en) begin
        lru_m[bq[0].idx] = !way;
        void'(bq.pop_front());
      end
      if (v.uv && rdy) bq.push_back('{int'(v.ui), v.up, v.uw});
`ifdef BTB_FLUSH_EN
      if (v.fr) begin
        bq.delete();
        walk_left = SETS;
        walk_idx = 0;
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_upd_ready"}, upd_ready, 1);
    chk({nm, "_flush_busy"}, flush_busy, 0);
    chk({nm, "_inv_en"}, inv_en, 0);
    chk({nm, "_lru"}, lru_state, 0);
  endtask

  vec_t tab [18];
  vec_t v;

  initial begin
    tab[0]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    tab[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h08);
    tab[2]  = mk(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 8'h08);
    tab[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 8'h08);
    tab[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h28);
    tab[5]  = mk(0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 1, 8'h28);
    tab[6]  = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 8'h28);
    tab[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h28);
    tab[8]  = mk(0, 0, 0, 0, 1, 6, 0, 0, 1, 0, 0, 0, 1, 8'h28);
    tab[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h28);
    tab[10] = mk(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h28);
    tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h68);
    tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 1, 8'h68);
    tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h28);
    tab[14] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h28);
    tab[15] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 8'h28);
    tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 8'h2A);
    tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h28);
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) step(tab[i]);

    // flush with a stalled buffered update, second request mid-walk
    v = idle(); v.uv = 1; v.ui = 4; v.st = 1;
    step(v);
    v = idle(); v.st = 1; v.fr = 1;
    step(v);
`ifdef BTB_FLUSH_EN
    for (int i = 0; i < SETS; i++) begin
      chk("walk_busy", flush_busy, 1);
      chk("walk_index", inv_index, i);
      v = idle(); v.lv = 1; v.lh = 1; v.li = 3'(i); v.uv = 1; v.fr = (i == 3);
      step(v);
    end
    chk("post_walk_busy", flush_busy, 0);
    chk("post_walk_lru", lru_state, 0);
    step(idle());
    chk("dropped_update", wr_en, 0);
`else
    chk("noflush_busy", flush_busy, 0);
    chk("noflush_inv_en", inv_en, 0);
    step(idle());
    chk("noflush_update_kept", lru_state[4], 1);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.lv = 1'($urandom); v.li = 3'($urandom); v.lh = 1'($urandom); v.lw = 1'($urandom);
      v.uv = 1'($urandom); v.ui = 3'($urandom); v.up = 1'($urandom); v.uw = 1'($urandom);
      v.st = ($urandom % 10) < 3;
      v.fr = ($urandom % 60) == 0;
      step(v);
    end
    while (walk_left > 0) step(idle());

    // reset with a buffered update and a non-zero LRU
    for (int i = 0; i < SETS; i++) begin
      v = idle(); v.lv = 1; v.lh = 1; v.li = 3'(i); v.lw = 0;
      step(v);
    end
    v = idle(); v.uv = 1; v.ui = 7; v.st = 1;
    step(v);
    chk("pre_reset_lru", lru_state, 8'hFF);
    wr_stall = 0;
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(idle());
`ifdef BTB_FLUSH_EN
    v = idle(); v.fr = 1;
    step(v);
    step(idle());
    rst_n = 1'b0;
    #1 check_reset_outputs("walk_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(idle());
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
